// File: rtl/s_term_cfg_loopback_matrix.sv
// South-termination loopback matrix: every southbound wire end is turned back north
// through a per-wire mode (pass / registered / tie-0 / tie-1), loaded by a shadow shift chain.

module s_term_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       src,
    output logic       out
);
    logic r;

    // r samples every cycle so a later switch into registered mode shows last cycle's src
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r <= 1'b0;
        else     r <= src;
    end

    always_comb begin
        out = src;
        unique case (mode)
            2'b00:   out = src;
            2'b01:   out = r;
            2'b10:   out = 1'b0;
            default: out = 1'b1;
        endcase
    end
endmodule

module s_term_cfg_loopback_matrix #(
    parameter int WIDTH   = 52,
    parameter bit REVERSE = 1'b1,
    parameter int CFG_LEN = 2*WIDTH+2
) (
    input  logic             UserCLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] s_end,
    output logic [WIDTH-1:0] n_beg,
    output logic             co,
    input  logic             cfg_in,
    input  logic             cfg_shift,
    input  logic             cfg_commit,
    output logic             cfg_out
);
    logic [WIDTH-1:0]   src;
    logic [CFG_LEN-1:0] shadow;
    logic [CFG_LEN-1:0] active;
    logic               t;
    logic               p;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        if (REVERSE) begin : g_rev
            assign src[i] = s_end[WIDTH-1-i];
        end else begin : g_fwd
            assign src[i] = s_end[i];
        end

        s_term_lane u_lane (
            .clk  (UserCLK),
            .rst  (RESET),
            .mode (active[2*i+1:2*i]),
            .src  (src[i]),
            .out  (n_beg[i])
        );
    end

    // Shadow shifts freely; the fabric only sees it after an explicit commit.
    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (cfg_shift)  shadow <= {shadow[CFG_LEN-2:0], cfg_in};
            if (cfg_commit) active <= shadow;
        end
    end

    assign cfg_out = shadow[CFG_LEN-1];

    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            t <= 1'b0;
            p <= 1'b0;
        end else begin
            t <= ~t;
            p <= ^src;
        end
    end

    always_comb begin
        co = 1'b0;
        unique case (active[CFG_LEN-1:CFG_LEN-2])
            2'b00:   co = 1'b0;
            2'b01:   co = 1'b1;
            2'b10:   co = t;
            default: co = p;
        endcase
    end
endmodule
